// File: rtl/sync_down_counter_if.sv
// Control/status bundle for sync_down_counter: load/enable requests in, count and flags out.
interface sync_down_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             count_en;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             tc;

  modport master (output load, load_val, count_en, input q, busy, done, tc);
  modport slave  (input load, load_val, count_en, output q, busy, done, tc);
endinterface

// File: rtl/sync_down_counter.sv
// Loadable down-counter/timer with one-cycle done pulse and cascadable terminal-count borrow.
// Build option DOWN_CNT_AUTO_RELOAD_EN: periodic reload from the last loaded value instead of one-shot.
module sync_down_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  sync_down_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] CNT_ZERO = WIDTH'(0);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic             r_busy;
  logic             r_done;

`ifdef DOWN_CNT_AUTO_RELOAD_EN
  logic [WIDTH-1:0] r_reload;

  // Period register follows every load so the timer repeats the last programmed value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reload <= CNT_ZERO;
    end else if (bus.load) begin
      r_reload <= bus.load_val;
    end
  end
`endif

  // State, count and decoded Moore flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_q     <= CNT_ZERO;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  // Load beats everything; a zero load goes straight to DONE so RUN never sees q==0.
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    if (bus.load) begin
      w_q_nxt     = bus.load_val;
      w_state_nxt = (bus.load_val != CNT_ZERO) ? ST_RUN : ST_DONE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_IDLE;
        end
        ST_RUN: begin
          if (bus.count_en) begin
            w_q_nxt = r_q - CNT_ONE;
            if (r_q == CNT_ONE) begin
              w_state_nxt = ST_DONE;
            end
          end
        end
        ST_DONE: begin
`ifdef DOWN_CNT_AUTO_RELOAD_EN
          if (r_reload != CNT_ZERO) begin
            w_q_nxt     = r_reload;
            w_state_nxt = ST_RUN;
          end
`else
          w_state_nxt = ST_IDLE;
`endif
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_q_nxt     = CNT_ZERO;
        end
      endcase
    end
  end

  assign bus.q    = r_q;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  // Borrow into the next stage: asserted in the cycle whose edge reaches zero.
  assign bus.tc   = r_busy & bus.count_en & (r_q == CNT_ONE);

endmodule
